full_adder: RTL and testbench
=============================

// Module: full_adder
// PURPOSE
//   Single-bit full adder: leaf cell of the team's ripple-carry adders and ALU datapaths.
//   Sum and carry-out are purely combinational, with zero latency from a/b/cin.
//   Optional registered copies (s_q, cout_q) are provided for pipelined users.
//   One clock (clk); asynchronous, active-high reset (rst), which affects only the registered copies.
// PARAMETERS
//   REG_OUT  1  1: build s_q/cout_q/vld_q flops; 0: tie s_q/cout_q/vld_q to 0.
// PORTS
//   clk   in   1  clock; rising edge samples the registered copies.
//   rst   in   1  async active-high reset; clears s_q, cout_q and vld_q.
//   s     out  1  sum = a ^ b ^ cin, combinational.
//   cout  out  1  carry = (a&b) | (a&cin) | (b&cin), combinational.
//   a     in   1  addend bit.
//   b     in   1  addend bit.
//   cin   in   1  carry-in bit.
//   s_q   out  1  registered s.
//   cout_q out 1  registered cout.
//   vld_q out  1  1 from the first rising clk after rst deasserts; 0 during reset.
// BEHAVIOUR
//   - Declaration order is fixed: s, cout, a, b, cin, clk, rst, s_q, cout_q, vld_q.
//     Positional instances connecting only the first five ports remain legal.
//   - Combinational core:
//     - {cout,s} = a + b + cin (2-bit result, range 0..3).
//     - No clock dependency.
//     - Outputs settle within one simulation time step of any input change.
//   - Implementation:
//     - Two half adders plus an OR.
//     - p = a^b; g = a&b; s = p^cin; cout = g | (p&cin).
//   - X/Z on any input propagates to s/cout; no X-masking.
//   - rst=1 (async, immediate, independent of clk): s_q=0, cout_q=0, vld_q=0.
//   - rst held 1: registers stay 0 regardless of clk or inputs.
//   - rst=0, rising clk: s_q<=s, cout_q<=cout, vld_q<=1 (latency 1 cycle).
//   - rst asserted mid-operation clears the registers at once.
//     Combinational s/cout keep tracking the inputs, unaffected by rst.
//   - rst deassert coincident with a clk edge: that edge does not capture.
//     The first capture is on the next edge.
//   - Input change coincident with a clk edge: the flops capture pre-edge values.
//   - REG_OUT=0: s_q, cout_q and vld_q are constant 0; clk/rst are unused.
// TESTING
//   - Exhaustive truth table, no clock, 1 time unit per vector, s/cout in order:
//     000->0/0, 001->1/0, 010->1/0, 011->0/1, 100->1/0, 101->0/1, 110->0/1, 111->1/1.
//     Vector order is (a,b,cin). Checks use !== so X fails.
//   - Register path: rst=1 then 0; apply a=1,b=1,cin=0.
//     After 1 clk edge: s_q=0, cout_q=1, vld_q=1. Before that edge: vld_q=0.
//   - Async reset: with s_q=1 (a=1,b=1,cin=1 captured), pulse rst between clk edges.
//     s_q/cout_q/vld_q go 0 immediately. s/cout stay 1/1.
//   - Reset release on a clk edge: rst falls at the edge with a=1,b=0,cin=0.
//     s_q stays 0 until the following edge, then becomes 1.
//   - Input toggling between edges:
//     a,b,cin go 0,0,1 -> 1,1,1 mid-cycle; s/cout follow immediately.
//     s_q/cout_q change only at the edge, to 1/1.
//   - REG_OUT=0: clock 4 cycles with varied inputs; s_q=cout_q=vld_q=0 throughout.
//     Truth table still passes.

Source files
------------

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders, with optional registered
// copies of sum/carry and a valid flag for pipelined users.
module full_adder #(
   parameter bit REG_OUT = 1'b1
) (
   output logic s,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic clk,
   input  logic rst,
   output logic s_q,
   output logic cout_q,
   output logic vld_q
);

   // Returns {carry, sum}; plain gates so X/Z on an input propagates.
   function automatic logic [1:0] half_add(input logic x, input logic y);
      half_add = {x & y, x ^ y};
   endfunction

   logic [1:0] ha_ab;
   logic [1:0] ha_pc;
   logic       p;
   logic       g;

   assign ha_ab = half_add(a, b);
   assign p     = ha_ab[0];
   assign g     = ha_ab[1];
   assign ha_pc = half_add(p, cin);
   assign s     = ha_pc[0];
   assign cout  = g | ha_pc[1];

   generate
      if (REG_OUT) begin : g_reg
         logic s_d;
         logic cout_d;

         assign s_d    = s;
         assign cout_d = cout;

         // Capture registers; reset is asynchronous and only touches these copies.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s_q    <= 1'b0;
               cout_q <= 1'b0;
               vld_q  <= 1'b0;
            end else begin
               s_q    <= s_d;
               cout_q <= cout_d;
               vld_q  <= 1'b1;
            end
         end
      end else begin : g_noreg
         logic unused_clk_rst;

         assign unused_clk_rst = clk ^ rst;
         assign s_q            = 1'b0;
         assign cout_q         = 1'b0;
         assign vld_q          = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: directed truth-table/reset/timing checks plus a random
// phase where a scoreboard queue is drained by an independent monitor.
module tb_full_adder;

   logic clk = 1'b0;
   logic rst;
   logic a;
   logic b;
   logic cin;
   logic s, cout, s_q, cout_q, vld_q;
   logic s0, cout0, s_q0, cout_q0, vld_q0;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [1:0] exp_q[$];
   logic       mon_en   = 1'b0;

   always #5 clk = ~clk;

   full_adder #(.REG_OUT(1'b1)) dut (
      .s(s), .cout(cout), .a(a), .b(b), .cin(cin), .clk(clk), .rst(rst),
      .s_q(s_q), .cout_q(cout_q), .vld_q(vld_q)
   );

   full_adder #(.REG_OUT(1'b0)) dut0 (
      .s(s0), .cout(cout0), .a(a), .b(b), .cin(cin), .clk(clk), .rst(rst),
      .s_q(s_q0), .cout_q(cout_q0), .vld_q(vld_q0)
   );

   // Reference: the arithmetic sum of three bits, as {carry, sum}.
   function automatic logic [1:0] ref_add(input logic x, input logic y, input logic z);
      return {1'b0, x} + {1'b0, y} + {1'b0, z};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Scoreboard monitor: pops one expected value per capture the DUT presents.
   always @(posedge clk) begin
      logic [1:0] e;
      #1;
      if (mon_en) begin
         check("regout0_tied", {5'd0, s_q0, cout_q0, vld_q0}, 8'd0);
         if (vld_q) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL sb_underflow: capture with empty queue at t=%0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("sb_reg", {6'd0, cout_q, s_q}, {6'd0, e});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] e;
      rst = 1'b1;
      a   = 1'b0;
      b   = 1'b0;
      cin = 1'b0;

      for (int i = 0; i < 8; i++) begin
         {a, b, cin} = 3'(i);
         #1;
         e = ref_add(a, b, cin);
         check("truth_table", {6'd0, s, cout}, {6'd0, e[0], e[1]});
         check("truth_table_r0", {6'd0, s0, cout0}, {6'd0, e[0], e[1]});
      end

      {a, b, cin} = 3'b111;
      @(posedge clk);
      #1;
      check("rst_hold", {5'd0, s_q, cout_q, vld_q}, 8'd0);

      @(negedge clk);
      {a, b, cin} = 3'b110;
      rst = 1'b0;
      #1;
      check("vld_before_edge", {7'd0, vld_q}, 8'd0);
      @(posedge clk);
      #1;
      check("reg_first_cap", {5'd0, s_q, cout_q, vld_q}, 8'b011);

      @(negedge clk);
      {a, b, cin} = 3'b111;
      @(posedge clk);
      #1;
      check("cap_111", {5'd0, s_q, cout_q, vld_q}, 8'b111);
      #2;
      rst = 1'b1;
      #1;
      check("async_clear", {5'd0, s_q, cout_q, vld_q}, 8'd0);
      check("comb_during_rst", {6'd0, s, cout}, 8'b11);
      @(posedge clk);
      #1;
      check("rst_held_edge", {5'd0, s_q, cout_q, vld_q}, 8'd0);

      {a, b, cin} = 3'b100;
      @(posedge clk);
      #0 rst = 1'b0;
      #1;
      check("release_edge_nocap", {5'd0, s_q, cout_q, vld_q}, 8'd0);
      @(posedge clk);
      #1;
      check("release_next_cap", {5'd0, s_q, cout_q, vld_q}, 8'b101);

      @(negedge clk);
      {a, b, cin} = 3'b001;
      @(posedge clk);
      #1;
      check("cap_001", {5'd0, s_q, cout_q, vld_q}, 8'b101);
      #2;
      {a, b, cin} = 3'b111;
      #1;
      check("comb_follow", {6'd0, s, cout}, 8'b11);
      check("no_midcycle_cap", {5'd0, s_q, cout_q, vld_q}, 8'b101);
      @(posedge clk);
      #1;
      check("toggle_cap", {5'd0, s_q, cout_q, vld_q}, 8'b111);

      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         {a, b, cin} = 3'($urandom_range(0, 7));
         e = ref_add(a, b, cin);
         exp_q.push_back(e);
         mon_en = 1'b1;
         #1;
         check("rand_comb", {6'd0, cout, s}, {6'd0, e});
         check("rand_comb_r0", {6'd0, cout0, s0}, {6'd0, e});
      end
      @(posedge clk);
      #2;
      mon_en = 1'b0;
      check("sb_drain", 8'(exp_q.size()), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
